// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate unit.
//   - in_op encodings (SHL, SHR, SRA, ROL, ROR); codes 5..7 are illegal
//   - FSM state enum used by the top-level controller
//   - op_legal(): 1 when an op code selects a real operation
package shift_pkg;

  localparam logic [2:0] OP_SHL = 3'd0;
  localparam logic [2:0] OP_SHR = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One conditional stage of the iterative shifter: moves data by 2^stage
// positions in the direction/kind selected by op when en is high,
// otherwise (or for an illegal op) passes data through unchanged.
// Ports:
//   data   in   WIDTH    value entering the stage
//   op     in   3        operation code (shift_pkg encodings)
//   stage  in   SHAMT_W  stage index k; move distance is 2^k
//   en     in   1        effective amount bit for this stage
//   result out  WIDTH    value leaving the stage
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] stage,
  input  logic               en,
  output logic [WIDTH-1:0]   result
);

  int unsigned sh;

  always_comb begin
    sh     = 32'd1 << stage;
    result = data;
    if (en) begin
      case (op)
        OP_SHL:  result = data << sh;
        OP_SHR:  result = data >> sh;
        OP_SRA:  result = $signed(data) >>> sh;
        // sh is at most WIDTH/2, so WIDTH-sh never reaches 0 or WIDTH
        OP_ROL:  result = (data << sh) | (data >> (WIDTH - sh));
        OP_ROR:  result = (data >> sh) | (data << (WIDTH - sh));
        default: result = data;
      endcase
    end
  end

endmodule

// File: rtl/shift_rotate_unit.sv
// Iterative shift/rotate unit with valid/ready handshakes on both sides.
// One request at a time; a single shift_stage is reused for SHAMT_W cycles,
// giving a fixed latency independent of op and amount.
// Ports:
//   clock       in   1      sole clock, rising edge
//   reset_n     in   1      synchronous active-low reset
//   in_valid    in   1      request present
//   in_ready    out  1      unit can accept a request
//   in_op       in   3      SHL/SHR/SRA/ROL/ROR, 5..7 illegal
//   in_a        in   WIDTH  operand
//   in_amt      in   WIDTH  shift/rotate amount, unsigned
//   out_valid   out  1      result present
//   out_ready   in   1      consumer accepts result
//   out_result  out  WIDTH  result
//   out_err     out  1      result came from an illegal op
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for a request, in_ready high
// ST_RUN  | applying stage k each cycle, k = 0 .. SHAMT_W-1
// ST_DONE | result presented, held until out_ready
module shift_rotate_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err
);

  localparam logic [SHAMT_W-1:0] K_LAST = SHAMT_W'(SHAMT_W - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q;
  logic [2:0]         op_q;
  logic [SHAMT_W-1:0] amt_q;
  logic               sat_q;
  logic               err_q;
  logic [SHAMT_W-1:0] k_q;

  logic               accept, last_stage;
  logic               in_legal, in_rot, in_big, in_sat;
  logic [WIDTH-1:0]   stage_out, sat_val;

  assign accept     = in_valid && in_ready;
  assign last_stage = (k_q == K_LAST);
  assign in_legal   = op_legal(in_op);
  assign in_rot     = (in_op == OP_ROL) || (in_op == OP_ROR);
  // WIDTH is a power of two, so any set bit above the low SHAMT_W means amt >= WIDTH
  assign in_big     = |in_amt[WIDTH-1:SHAMT_W];
  assign in_sat     = in_legal && !in_rot && in_big;
  // A saturated op runs with amount 0, so work_q still holds the original sign bit
  assign sat_val    = {WIDTH{work_q[WIDTH-1] & (op_q == OP_SRA)}};

  // amt_q shifts right every stage, so bit 0 is always amount bit k
  shift_stage #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_stage (
    .data   (work_q),
    .op     (op_q),
    .stage  (k_q),
    .en     (amt_q[0]),
    .result (stage_out)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)     state_d = ST_RUN;
      ST_RUN:  if (last_stage) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = reset_n && (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      work_q <= '0;
      op_q   <= '0;
      amt_q  <= '0;
      sat_q  <= 1'b0;
      err_q  <= 1'b0;
      k_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            work_q <= in_a;
            op_q   <= in_op;
            amt_q  <= (in_legal && !in_sat) ? in_amt[SHAMT_W-1:0] : '0;
            sat_q  <= in_sat;
            err_q  <= !in_legal;
            k_q    <= '0;
          end
        end
        ST_RUN: begin
          amt_q <= amt_q >> 1;
          if (last_stage) begin
            work_q <= sat_q ? sat_val : stage_out;
            k_q    <= '0;
          end else begin
            work_q <= stage_out;
            k_q    <= k_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_result = work_q;
  assign out_err    = err_q;

endmodule
